regfile_ir_seq: RTL and testbench

- Parametrised instruction register file. Successor to the single-port IR store.
- Adds a handshaked burst-load engine, a sequential fetch port with auto-incrementing PC and jump, and a random read port with write-to-read bypass.
- Sits between the loader/bus side and the instruction decode front end.

---
 rtl/regfile_ir_seq_pkg.sv | 11 +
 rtl/regfile_ir_mem.sv | 34 +++
 rtl/regfile_ir_seq.sv | 97 +++++++++
 tb/tb_regfile_ir_seq.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/regfile_ir_seq_pkg.sv
// regfile_ir_seq_pkg: shared defaults, load FSM encodings and ld_len width rule
package regfile_ir_seq_pkg;
  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_ADDR_WIDTH = 4;
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_LOAD = 1'b1;
  // ld_len must encode 2**aw itself, so it needs one bit more than an address
  function automatic int len_width(input int aw);
    return aw + 1;
  endfunction
endpackage

// File: rtl/regfile_ir_mem.sv
// regfile_ir_mem: one-write, two-registered-read storage with per-port write bypass
module regfile_ir_mem #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 4,
  parameter bit RESET_CLEAR = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] wa,
  input  logic [DATA_WIDTH-1:0] wd,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  fe_en,
  input  logic [ADDR_WIDTH-1:0] fe_addr,
  output logic [DATA_WIDTH-1:0] fe_data
);
  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
  // storage write; reset clearing is optional so large arrays can map to RAM
  always_ff @(posedge clk)
    if (rst && RESET_CLEAR)
      for (int i = 0; i < 2**ADDR_WIDTH; i++) mem[i] <= '0;
    else if (we)
      mem[wa] <= wd;
  // registered read ports; a same-cycle write to the read address forwards its data
  always_ff @(posedge clk)
    if (rst) begin
      rd_data <= '0;
      fe_data <= '0;
    end else begin
      rd_data <= (we && wa == rd_addr) ? wd : mem[rd_addr];
      if (fe_en) fe_data <= (we && wa == fe_addr) ? wd : mem[fe_addr];
    end
endmodule

// File: rtl/regfile_ir_seq.sv
// regfile_ir_seq: instruction register file with burst loader, sequential fetch and random read
module regfile_ir_seq
  import regfile_ir_seq_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter bit RESET_CLEAR = 1'b1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              wr_en,
  input  logic [ADDR_WIDTH-1:0]             wr_addr,
  input  logic [DATA_WIDTH-1:0]             wr_data,
  input  logic [ADDR_WIDTH-1:0]             rd_addr,
  output logic [DATA_WIDTH-1:0]             rd_data,
  input  logic                              ld_start,
  input  logic [ADDR_WIDTH-1:0]             ld_base,
  input  logic [len_width(ADDR_WIDTH)-1:0]  ld_len,
  input  logic                              ld_valid,
  input  logic [DATA_WIDTH-1:0]             ld_data,
  output logic                              ld_ready,
  output logic                              ld_done,
  output logic                              busy,
  output logic                              wr_drop,
  input  logic                              fe_req,
  input  logic                              fe_jump,
  input  logic [ADDR_WIDTH-1:0]             fe_target,
  output logic                              fe_valid,
  output logic [DATA_WIDTH-1:0]             fe_data,
  output logic [ADDR_WIDTH-1:0]             fe_pc
);
  localparam int LW = len_width(ADDR_WIDTH);
  logic [0:0]            state;
  logic [ADDR_WIDTH-1:0] ptr;
  logic [LW-1:0]         remain;
  logic                  beat, last, we, fe_en;
  logic [ADDR_WIDTH-1:0] wa, fa;
  logic [DATA_WIDTH-1:0] wd;
  assign busy = state == ST_LOAD;
  assign ld_ready = busy;
  // write-port arbitration: load beats own the port in LOAD, random writes in IDLE
  always_comb begin
    beat = busy && ld_valid;
    last = beat && remain == LW'(1);
    we = !rst && (beat || (!busy && wr_en));
    wa = beat ? ptr : wr_addr;
    wd = beat ? ld_data : wr_data;
    fe_en = !rst && !busy && fe_req;
    fa = fe_jump ? fe_target : fe_pc;
  end
  // burst-load FSM with beat pointer, remaining count, done and drop pulses
  always_ff @(posedge clk)
    if (rst) begin
      state <= ST_IDLE;
      ptr <= '0;
      remain <= '0;
      ld_done <= 1'b0;
      wr_drop <= 1'b0;
    end else begin
      ld_done <= last;
      wr_drop <= busy && wr_en;
      if (!busy && ld_start && ld_len != '0) begin
        state <= ST_LOAD;
        ptr <= ld_base;
        remain <= ld_len;
      end else if (beat) begin
        ptr <= ptr + 1'b1;
        remain <= remain - 1'b1;
        if (last) state <= ST_IDLE;
      end
    end
  // fetch PC: advance past the fetched word, or redirect on a jump even while busy
  always_ff @(posedge clk)
    if (rst) begin
      fe_valid <= 1'b0;
      fe_pc <= '0;
    end else begin
      fe_valid <= fe_en;
      fe_pc <= fe_en ? fa + 1'b1 : fe_jump ? fe_target : fe_pc;
    end
  regfile_ir_mem #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH),
    .RESET_CLEAR(RESET_CLEAR)
  ) u_mem (
    .clk(clk),
    .rst(rst),
    .we(we),
    .wa(wa),
    .wd(wd),
    .rd_addr(rd_addr),
    .rd_data(rd_data),
    .fe_en(fe_en),
    .fe_addr(fa),
    .fe_data(fe_data)
  );
endmodule

// File: tb/tb_regfile_ir_seq.sv
// tb_regfile_ir_seq: directed plus random checks against a queue-based reference model
module tb_regfile_ir_seq;
  localparam int DW = 16, AW = 4, N = 16;
  logic clk = 1'b0, rst;
  logic wr_en, ld_start, ld_valid, ld_ready, ld_done, busy, wr_drop;
  logic fe_req, fe_jump, fe_valid;
  logic [AW-1:0] wr_addr, rd_addr, ld_base, fe_target, fe_pc;
  logic [AW:0] ld_len;
  logic [DW-1:0] wr_data, rd_data, ld_data, fe_data;
  int total = 0, bad = 0;
  logic [DW-1:0] m [N];
  int q[$];
  logic [DW-1:0] e_rd, e_fd;
  logic e_fv, e_done, e_drop;
  logic [AW-1:0] e_pc;

  regfile_ir_seq #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RESET_CLEAR(1'b1)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data), .ld_start(ld_start), .ld_base(ld_base),
    .ld_len(ld_len), .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready),
    .ld_done(ld_done), .busy(busy), .wr_drop(wr_drop), .fe_req(fe_req),
    .fe_jump(fe_jump), .fe_target(fe_target), .fe_valid(fe_valid),
    .fe_data(fe_data), .fe_pc(fe_pc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clr_in;
    wr_en = 0; wr_addr = 0; wr_data = 0; rd_addr = 0;
    ld_start = 0; ld_base = 0; ld_len = 0; ld_valid = 0; ld_data = 0;
    fe_req = 0; fe_jump = 0; fe_target = 0;
  endtask

  // model the cycle from current inputs, clock once, compare every output
  task automatic tick;
    logic bz, we;
    logic [AW-1:0] wa, a;
    logic [DW-1:0] wd;
    bz = q.size() != 0;
    we = 0; wa = '0; wd = '0;
    if (bz && ld_valid) begin we = 1; wa = AW'(q[0]); wd = ld_data; end
    else if (!bz && wr_en) begin we = 1; wa = wr_addr; wd = wr_data; end
    e_done = bz && ld_valid && q.size() == 1;
    e_drop = bz && wr_en;
    e_rd = (we && wa == rd_addr) ? wd : m[rd_addr];
    if (!bz && fe_req) begin
      a = fe_jump ? fe_target : e_pc;
      e_fd = (we && wa == a) ? wd : m[a];
      e_fv = 1;
      e_pc = a + 1'b1;
    end else begin
      e_fv = 0;
      if (fe_jump) e_pc = fe_target;
    end
    if (we) m[wa] = wd;
    if (bz && ld_valid) void'(q.pop_front());
    if (!bz && ld_start && ld_len != 0)
      for (int i = 0; i < int'(ld_len); i++) q.push_back((int'(ld_base) + i) % N);
    if (rst) begin
      q.delete();
      foreach (m[i]) m[i] = '0;
      e_rd = 0; e_fd = 0; e_fv = 0; e_pc = 0; e_done = 0; e_drop = 0;
    end
    @(posedge clk);
    #1;
    chk("rd_data", 32'(rd_data), 32'(e_rd));
    chk("fe_data", 32'(fe_data), 32'(e_fd));
    chk("fe_valid", 32'(fe_valid), 32'(e_fv));
    chk("fe_pc", 32'(fe_pc), 32'(e_pc));
    chk("ld_done", 32'(ld_done), 32'(e_done));
    chk("wr_drop", 32'(wr_drop), 32'(e_drop));
    chk("busy", 32'(busy), 32'(q.size() != 0));
    chk("ld_ready", 32'(ld_ready), 32'(q.size() != 0));
  endtask

  initial begin
    e_rd = 0; e_fd = 0; e_fv = 0; e_pc = 0; e_done = 0; e_drop = 0;
    foreach (m[i]) m[i] = '0;
    clr_in();
    rst = 1;
    tick(); tick();
    rst = 0;
    chk("reset_fe_pc", 32'(fe_pc), 0);
    chk("reset_busy", 32'(busy), 0);
    // burst that wraps past the top, beats gapped, with a dropped random write
    ld_start = 1; ld_base = 14; ld_len = 4;
    tick();
    clr_in();
    for (int k = 0; k < 8; k++) begin
      ld_valid = (k % 2 == 0);
      ld_data = 16'hA000 + 16'(k / 2);
      wr_en = (k == 1); wr_addr = 3; wr_data = 16'h1234;
      tick();
      if (k == 1) chk("drop_pulse", 32'(wr_drop), 1);
      if (k == 6) begin
        chk("burst_done", 32'(ld_done), 1);
        chk("burst_busy_fall", 32'(busy), 0);
      end
    end
    clr_in();
    chk("done_once", 32'(ld_done), 0);
    rd_addr = 14; tick(); chk("burst_mem14", 32'(rd_data), 32'h A000);
    rd_addr = 1; tick(); chk("burst_mem1", 32'(rd_data), 32'h A003);
    rd_addr = 3; tick(); chk("drop_mem3", 32'(rd_data), 0);
    wr_en = 1; wr_addr = 3; wr_data = 16'h1234; tick();
    clr_in(); rd_addr = 3; tick(); chk("idle_write", 32'(rd_data), 32'h1234);
    // write-to-read bypass
    wr_en = 1; wr_addr = 5; wr_data = 16'hBEEF; rd_addr = 5; tick();
    chk("bypass", 32'(rd_data), 32'hBEEF);
    // sequential fetch then jump to the top address
    for (int i = 0; i < 3; i++) begin
      wr_en = 1; wr_addr = AW'(i); wr_data = 16'h0100 + 16'(i); tick();
    end
    clr_in(); fe_jump = 1; fe_target = 0; tick();
    clr_in();
    for (int i = 0; i < 3; i++) begin
      fe_req = 1; tick();
      chk("fetch_data", 32'(fe_data), 32'h0100 + i);
      chk("fetch_pc", 32'(fe_pc), i + 1);
    end
    fe_jump = 1; fe_target = 15; tick();
    chk("jump_data", 32'(fe_data), 32'h A001);
    chk("jump_pc", 32'(fe_pc), 0);
    // fetch held across a 2-beat load
    clr_in(); fe_req = 1;
    ld_start = 1; ld_base = 8; ld_len = 2; tick();
    ld_start = 0; ld_valid = 1;
    ld_data = 16'h5550; tick(); chk("stall_v0", 32'(fe_valid), 0);
    ld_data = 16'h5551; tick(); chk("stall_v1", 32'(fe_valid), 0);
    ld_valid = 0; tick(); chk("resume_v", 32'(fe_valid), 1);
    // reset in the middle of a load
    clr_in();
    ld_start = 1; ld_base = 4; ld_len = 4; tick();
    ld_start = 0; ld_valid = 1; ld_data = 16'h7777; tick(); tick();
    clr_in(); rst = 1; tick();
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_pc", 32'(fe_pc), 0);
    rst = 0; tick();
    chk("mid_rst_no_done", 32'(ld_done), 0);
    for (int i = 0; i < N; i++) begin rd_addr = AW'(i); tick(); end
    // randomized traffic
    for (int c = 0; c < 400; c++) begin
      rst = ($urandom_range(0, 99) == 0);
      wr_en = ($urandom_range(0, 2) == 0);
      wr_addr = AW'($urandom); wr_data = DW'($urandom);
      rd_addr = AW'($urandom);
      ld_start = ($urandom_range(0, 9) == 0);
      ld_base = AW'($urandom); ld_len = (AW+1)'($urandom_range(0, N));
      ld_valid = $urandom_range(0, 1) == 1; ld_data = DW'($urandom);
      fe_req = $urandom_range(0, 1) == 1;
      fe_jump = ($urandom_range(0, 5) == 0); fe_target = AW'($urandom);
      tick();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
